// File: rtl/mod_feed_pkg.sv
// Shared types and constants for the modulation segment feeder.
// Holds the FSM state enum, the Q16 carrier table and the default word/symbol sizing.
package mod_feed_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WORD_W              = 32;
  localparam int DEF_SAMPLES_PER_BIT = 8;
  localparam int ROM_DEPTH           = 8;

  // One carrier period in signed Q16: 65536*sin(2*pi*k/8), rounded to nearest.
  localparam logic [31:0] CARRIER_ROM [ROM_DEPTH] = '{
    32'h0000_0000, 32'h0000_B505, 32'h0001_0000, 32'h0000_B505,
    32'h0000_0000, 32'hFFFF_4AFB, 32'hFFFF_0000, 32'hFFFF_4AFB
  };

  function automatic logic [31:0] q16_negate(input logic [31:0] i_val);
    return ~i_val + 32'd1;
  endfunction

endpackage

// File: rtl/carrier_rom.sv
// Combinational carrier lookup: 3-bit phase into the package Q16 table.
module carrier_rom
  import mod_feed_pkg::*;
(
  input  logic [2:0]  i_phase,
  output logic [31:0] o_sample
);

  assign o_sample = CARRIER_ROM[i_phase];

endmodule

// File: rtl/modulation_segment_feeder.sv
// Serialises 32-bit payload words MSB-first into BPSK segment inputs (bit, carrier, -carrier).
// Define MOD_FEED_PRELOAD_EN to add a one-word holding register for gapless back-to-back words.
module modulation_segment_feeder
  import mod_feed_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
  parameter int WORD_W          = mod_feed_pkg::WORD_W
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [31:0]       input_bit,
  output logic [31:0]       array_ref_wire,
  output logic [31:0]       array_ref_m_wire,
  output logic              seg_valid,
  output logic [4:0]        seg_idx,
  output logic              frame_done,
  output state_t            o_dbg_state
);

  localparam int         SAMP_STEP = 8 / SAMPLES_PER_BIT;
  localparam logic [2:0] SAMP_LAST = 3'(SAMPLES_PER_BIT - 1);
  localparam logic [4:0] BIT_LAST  = 5'(WORD_W - 1);

  state_t            r_state, w_nxt_state;
  logic [WORD_W-1:0] r_shift, w_nxt_shift;
  logic [4:0]        r_bit_cnt, w_nxt_bit_cnt;
  logic [2:0]        r_samp_cnt, w_nxt_samp_cnt;
  logic              w_take;
  logic              w_last;
  logic              w_nxt_ready;
  logic              w_nxt_frame_done;
  logic [2:0]        w_phase;
  logic [31:0]       w_carrier;

  logic              r_in_ready;
  logic [31:0]       r_input_bit;
  logic [31:0]       r_ref;
  logic [31:0]       r_ref_m;
  logic              r_seg_valid;
  logic [4:0]        r_seg_idx;
  logic              r_frame_done;

`ifdef MOD_FEED_PRELOAD_EN
  logic [WORD_W-1:0] r_hold, w_nxt_hold;
  logic              r_hold_full, w_nxt_hold_full;
`endif

  // Handshake: a word transfers on a rising edge where in_valid && in_ready are both high;
  // in_ready never depends on in_valid and the producer holds in_data steady until the transfer.
  assign w_take = in_valid && r_in_ready;
  assign w_last = (r_state == RUN) && (r_bit_cnt == BIT_LAST) && (r_samp_cnt == SAMP_LAST);

  // Counters hold the position currently on the outputs, so the output registers
  // are loaded from the next position to keep them aligned with the counters.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_shift    = r_shift;
    w_nxt_bit_cnt  = r_bit_cnt;
    w_nxt_samp_cnt = r_samp_cnt;
`ifdef MOD_FEED_PRELOAD_EN
    w_nxt_hold      = r_hold;
    w_nxt_hold_full = r_hold_full;
`endif
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_nxt_state    = RUN;
          w_nxt_shift    = in_data;
          w_nxt_bit_cnt  = '0;
          w_nxt_samp_cnt = '0;
        end
      end
      RUN: begin
        if (w_last) begin
          w_nxt_bit_cnt  = '0;
          w_nxt_samp_cnt = '0;
`ifdef MOD_FEED_PRELOAD_EN
          if (r_hold_full) begin
            w_nxt_shift     = r_hold;
            w_nxt_hold_full = 1'b0;
          end else if (w_take) begin
            w_nxt_shift = in_data;
          end else begin
            w_nxt_state = IDLE;
            w_nxt_shift = '0;
          end
`else
          w_nxt_state = IDLE;
          w_nxt_shift = '0;
`endif
        end else begin
          if (r_samp_cnt == SAMP_LAST) begin
            w_nxt_samp_cnt = '0;
            w_nxt_bit_cnt  = r_bit_cnt + 5'd1;
            w_nxt_shift    = {r_shift[WORD_W-2:0], 1'b0};
          end else begin
            w_nxt_samp_cnt = r_samp_cnt + 3'd1;
          end
`ifdef MOD_FEED_PRELOAD_EN
          if (w_take) begin
            w_nxt_hold      = in_data;
            w_nxt_hold_full = 1'b1;
          end
`endif
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

`ifdef MOD_FEED_PRELOAD_EN
  assign w_nxt_ready = (w_nxt_state == IDLE) || !w_nxt_hold_full;
`else
  assign w_nxt_ready = (w_nxt_state == IDLE);
`endif

  assign w_nxt_frame_done = (w_nxt_state == RUN) && (w_nxt_bit_cnt == BIT_LAST) &&
                            (w_nxt_samp_cnt == SAMP_LAST);
  assign w_phase          = 3'(w_nxt_samp_cnt * SAMP_STEP);

  carrier_rom u_carrier_rom (
    .i_phase  (w_phase),
    .o_sample (w_carrier)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_samp_cnt   <= '0;
      r_in_ready   <= 1'b0;
      r_input_bit  <= '0;
      r_ref        <= '0;
      r_ref_m      <= '0;
      r_seg_valid  <= 1'b0;
      r_seg_idx    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_shift    <= w_nxt_shift;
      r_bit_cnt  <= w_nxt_bit_cnt;
      r_samp_cnt <= w_nxt_samp_cnt;
      r_in_ready <= w_nxt_ready;
      if (w_nxt_state == RUN) begin
        r_input_bit  <= {31'd0, w_nxt_shift[WORD_W-1]};
        r_ref        <= w_carrier;
        r_ref_m      <= q16_negate(w_carrier);
        r_seg_valid  <= 1'b1;
        r_seg_idx    <= w_nxt_bit_cnt;
        r_frame_done <= w_nxt_frame_done;
      end else begin
        r_input_bit  <= '0;
        r_ref        <= '0;
        r_ref_m      <= '0;
        r_seg_valid  <= 1'b0;
        r_seg_idx    <= '0;
        r_frame_done <= 1'b0;
      end
    end
  end

`ifdef MOD_FEED_PRELOAD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_hold      <= w_nxt_hold;
      r_hold_full <= w_nxt_hold_full;
    end
  end
`endif

  assign in_ready         = r_in_ready;
  assign input_bit        = r_input_bit;
  assign array_ref_wire   = r_ref;
  assign array_ref_m_wire = r_ref_m;
  assign seg_valid        = r_seg_valid;
  assign seg_idx          = r_seg_idx;
  assign frame_done       = r_frame_done;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_modulation_segment_feeder.sv
// Scoreboard bench for modulation_segment_feeder: two instances (8 and 4 samples per bit),
// expectations built from the bit/carrier rules and checked by per-instance monitors.
module tb_modulation_segment_feeder;
  import mod_feed_pkg::*;

  logic        clk;
  logic        reset;

  logic        a_in_valid, a_in_ready;
  logic [31:0] a_in_data, a_input_bit, a_ref, a_ref_m;
  logic        a_seg_valid, a_frame_done;
  logic [4:0]  a_seg_idx;
  state_t      a_dbg;

  logic        b_in_valid, b_in_ready;
  logic [31:0] b_in_data, b_input_bit, b_ref, b_ref_m;
  logic        b_seg_valid, b_frame_done;
  logic [4:0]  b_seg_idx;
  state_t      b_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [101:0] exp_q_a[$];
  logic [101:0] exp_q_b[$];
  int runs_a[$];
  int gaps_a[$];
  int a_run = 0;
  int a_gap = 0;
  int b_valid_cnt = 0;

  int signed carrier_tbl[8] = '{0, 46341, 65536, 46341, 0, -46341, -65536, -46341};

  modulation_segment_feeder #(.SAMPLES_PER_BIT(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .input_bit(a_input_bit), .array_ref_wire(a_ref), .array_ref_m_wire(a_ref_m),
    .seg_valid(a_seg_valid), .seg_idx(a_seg_idx), .frame_done(a_frame_done), .o_dbg_state(a_dbg)
  );

  modulation_segment_feeder #(.SAMPLES_PER_BIT(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .input_bit(b_input_bit), .array_ref_wire(b_ref), .array_ref_m_wire(b_ref_m),
    .seg_valid(b_seg_valid), .seg_idx(b_seg_idx), .frame_done(b_frame_done), .o_dbg_state(b_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [101:0] pack_a();
    return {a_frame_done, a_seg_idx, a_input_bit, a_ref, a_ref_m};
  endfunction

  function automatic logic [101:0] pack_b();
    return {b_frame_done, b_seg_idx, b_input_bit, b_ref, b_ref_m};
  endfunction

  function automatic int run_at(input int i);
    return (i < runs_a.size()) ? runs_a[i] : -1;
  endfunction

  function automatic int gap_at(input int i);
    return (i < gaps_a.size()) ? gaps_a[i] : -1;
  endfunction

  // Reference model: one entry per output cycle, bit b of the word sent MSB-first,
  // carrier sampled at phase s/spb of one period, second output is the arithmetic negation.
  task automatic push_word(input bit to_b, input logic [31:0] w, input int spb);
    for (int b = 0; b < 32; b++) begin
      for (int s = 0; s < spb; s++) begin
        logic [31:0]  r;
        logic [31:0]  m;
        logic [101:0] e;
        r = 32'(carrier_tbl[(s * 8) / spb]);
        m = 32'(0 - carrier_tbl[(s * 8) / spb]);
        e = {(b == 31 && s == spb - 1), 5'(b), 31'd0, w[31 - b], r, m};
        if (to_b) exp_q_b.push_back(e);
        else      exp_q_a.push_back(e);
      end
    end
  endtask

  // Driver tasks
  task automatic send(input bit to_b, input logic [31:0] w);
    int g = 0;
    @(negedge clk);
    if (to_b) begin b_in_valid = 1'b1; b_in_data = w; end
    else      begin a_in_valid = 1'b1; a_in_data = w; end
    while (!(to_b ? b_in_ready : a_in_ready) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      check("handshake_timeout", to_b ? b_in_ready : a_in_ready, 1);
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
    end else begin
      push_word(to_b, w, to_b ? 4 : 8);
      @(posedge clk);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic drain(input bit to_b, input string name);
    int g = 0;
    while (((to_b ? exp_q_b.size() : exp_q_a.size()) != 0 ||
            (to_b ? b_seg_valid : a_seg_valid)) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check({name, "_drain_left"}, to_b ? exp_q_b.size() : exp_q_a.size(), 0);
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (reset) begin
      a_run = 0;
      a_gap = 0;
    end else if (a_seg_valid) begin
      if (a_run == 0) gaps_a.push_back(a_gap);
      a_run++;
      a_gap = 0;
`ifndef MOD_FEED_PRELOAD_EN
      check("a_in_ready_in_run", a_in_ready, 0);
`endif
      if (exp_q_a.size() == 0) check("a_unexpected_valid", a_seg_valid, 0);
      else check("a_segment", pack_a(), exp_q_a.pop_front());
    end else begin
      if (a_run != 0) runs_a.push_back(a_run);
      a_run = 0;
      a_gap++;
      check("a_idle_zero", pack_a(), 0);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (b_seg_valid) begin
        b_valid_cnt++;
        if (exp_q_b.size() == 0) check("b_unexpected_valid", b_seg_valid, 0);
        else check("b_segment", pack_b(), exp_q_b.pop_front());
      end else begin
        check("b_idle_zero", pack_b(), 0);
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] w;
    int g;
    a_in_valid = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_in_data = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a_in_ready", a_in_ready, 0);
    check("rst_b_in_ready", b_in_ready, 0);
    check("rst_a_outputs", {a_seg_valid, pack_a()}, 0);
    check("rst_a_state", a_dbg, IDLE);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rel_a_in_ready", a_in_ready, 1);
    check("rel_b_in_ready", b_in_ready, 1);

    // Single word 0x8000_0001
    runs_a.delete(); gaps_a.delete();
    send(0, 32'h8000_0001);
    idle_in();
    check("t1_state_run", a_dbg, RUN);
    drain(0, "t1");
    check("t1_run_count", runs_a.size(), 1);
    check("t1_run_len", run_at(0), 256);

    // Back-to-back 0xFFFF_FFFF then 0x0000_0000
    runs_a.delete(); gaps_a.delete();
    send(0, 32'hFFFF_FFFF);
    send(0, 32'h0000_0000);
    idle_in();
    drain(0, "b2b");
`ifdef MOD_FEED_PRELOAD_EN
    check("b2b_run_count", runs_a.size(), 1);
    check("b2b_run_len", run_at(0), 512);
`else
    check("b2b_run_count", runs_a.size(), 2);
    check("b2b_run0_len", run_at(0), 256);
    check("b2b_run1_len", run_at(1), 256);
    check("b2b_gap", gap_at(1), 1);
`endif

    // Three words offered during RUN
    runs_a.delete(); gaps_a.delete();
    send(0, $urandom());
    #1;
`ifdef MOD_FEED_PRELOAD_EN
    check("w3_ready_after_first", a_in_ready, 1);
`else
    check("w3_ready_after_first", a_in_ready, 0);
`endif
    send(0, $urandom());
    #1;
    check("w3_ready_after_second", a_in_ready, 0);
    send(0, $urandom());
    idle_in();
    drain(0, "w3");
`ifdef MOD_FEED_PRELOAD_EN
    check("w3_run_count", runs_a.size(), 1);
    check("w3_run_len", run_at(0), 768);
`else
    check("w3_run_count", runs_a.size(), 3);
    check("w3_run2_len", run_at(2), 256);
    check("w3_gap1", gap_at(1), 1);
    check("w3_gap2", gap_at(2), 1);
`endif

    // Reset mid-word at seg_idx 10; partial and held words are discarded
    send(0, $urandom());
`ifdef MOD_FEED_PRELOAD_EN
    send(0, $urandom());
`endif
    idle_in();
    g = 0;
    while (a_seg_idx != 5'd10 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("midrst_reach_idx10", a_seg_idx, 10);
    @(posedge clk); #2 reset = 1'b1;
    exp_q_a.delete();
    exp_q_b.delete();
    @(negedge clk);
    check("midrst_outputs", {a_seg_valid, pack_a()}, 0);
    check("midrst_in_ready", a_in_ready, 0);
    check("midrst_state", a_dbg, IDLE);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_rel_in_ready", a_in_ready, 1);
    runs_a.delete(); gaps_a.delete();
    send(0, $urandom());
    idle_in();
    check("midrst_new_idx0", {a_seg_valid, a_seg_idx}, {1'b1, 5'd0});
    drain(0, "midrst");
    check("midrst_run_len", run_at(0), 256);

    // Random words with random idle spacing
    for (int i = 0; i < 4; i++) begin
      w = $urandom();
      send(0, w);
      idle_in();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(0, "rand");

    // 4 samples per bit, word 0xA5A5_A5A5
    b_valid_cnt = 0;
    send(1, 32'hA5A5_A5A5);
    idle_in();
    drain(1, "spb4");
    check("spb4_valid_cycles", b_valid_cnt, 128);

    check("final_queue_a", exp_q_a.size(), 0);
    check("final_queue_b", exp_q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modulation_segment_feeder.md
# modulation_segment_feeder

Upstream stage of the unrolled modulation segments. It accepts 32-bit payload words over a valid/ready handshake and serialises them MSB-first, one bit per symbol period. Each symbol period is `SAMPLES_PER_BIT` clock cycles. Every cycle it presents three things to the per-segment if/else combiners:

- the current bit (`input_bit`);
- the carrier sample (`array_ref_wire`);
- the negated carrier sample (`array_ref_m_wire`).

The combiners then select the sample or its negation per bit, giving BPSK-style segments.

## Interface
Parameters:
- `SAMPLES_PER_BIT`, default 8: cycles per bit; legal values 2, 4, 8.
- `WORD_W`, default 32: payload bits per word; fixed at 32.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  payload word offered.
- `in_ready`  out  1  feeder can take a word this cycle.
- `in_data`  in  32  payload word; bit 31 is sent first.
- `input_bit`  out  32  current bit, zero-extended (32'd0 or 32'd1).
- `array_ref_wire`  out  32  carrier sample, signed Q16.
- `array_ref_m_wire`  out  32  two's-complement negation of `array_ref_wire`.
- `seg_valid`  out  1  the three data outputs are meaningful this cycle.
- `seg_idx`  out  5  index of the bit currently being sent, 0..31.
- `frame_done`  out  1  one-cycle pulse on the last sample of a word.

## Operation
- State machine states: IDLE, RUN.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: load the shift register, clear `bit_cnt` and `samp_cnt`, and go to RUN.
- RUN, every cycle:
  - `input_bit` = shift register bit 31, zero-extended.
  - `array_ref_wire` = `ROM[samp_cnt*(8/SAMPLES_PER_BIT)]`.
  - `seg_idx` = `bit_cnt`.
- Counter updates in RUN:
  - `samp_cnt` increments.
  - When `samp_cnt` is `SAMPLES_PER_BIT-1`, it wraps to 0, `bit_cnt` increments and the shift register shifts left by one.
- End of word: when `bit_cnt`=31 and `samp_cnt`=`SAMPLES_PER_BIT-1`, assert `frame_done` and take the next action from the Configuration section.
- Carrier ROM, 8 entries: 0, 46341, 65536, 46341, 0, -46341, -65536, -46341.
- Negation: `array_ref_m_wire` = `~array_ref_wire`+1, truncated to 32 bits. -2^31 maps to itself. The ROM never produces -2^31.
- Data-output values:
  - While `seg_valid`=0: `input_bit`, `array_ref_wire`, `array_ref_m_wire` and `seg_idx` are all 0.
  - All outputs are registered.
- `in_valid` with `in_ready`=0: the word is not taken; the producer must hold it.

## Timing
- Reset values: `in_ready`=0 while `reset` is asserted, then 1 in IDLE from the first cycle after release. All other outputs are 0 and the state is IDLE.
- Latency:
  - A handshake at edge k gives `seg_valid`=1 from cycle k+1.
  - `seg_valid` stays high for exactly 32×`SAMPLES_PER_BIT` cycles per word.
  - For the default, sample 0 of bit 0 appears in cycle k+1 and `frame_done` in cycle k+256.
- `input_bit` changes only on bit boundaries. The carrier changes every cycle.
- Reset asserted mid-word:
  - All registers clear immediately, with no further `seg_valid`.
  - Any partial word and any held word are discarded.
- A handshake and `frame_done` in the same cycle is legal only when the preload feature is compiled in.

## Configuration
- Macro: `MOD_FEED_PRELOAD_EN`.
- Defined:
  - A one-word holding register is added.
  - In RUN, `in_ready` = !`hold_full`; a handshake fills the holding register.
  - At end of word with `hold_full`=1: load the shift register from the holding register, clear `hold_full`, stay in RUN. Output is gapless: the next word's sample 0 is in the cycle after `frame_done`.
  - At end of word with `hold_full`=0: go to IDLE.
  - In IDLE, a handshake behaves as without the macro.
- Undefined:
  - `in_ready`=0 throughout RUN.
  - After `frame_done` the block returns to IDLE.
  - Earliest next handshake is cycle t+1 after `frame_done` at t; `seg_valid` restarts at t+2, so there is one gap cycle.

## Structure
- Package `mod_feed_pkg` holds:
  - the state enum (IDLE, RUN);
  - the 8-entry carrier constant array (Q16);
  - `WORD_W`;
  - the default `SAMPLES_PER_BIT`.
- Sub-module `carrier_rom`:
  - combinational lookup of the 3-bit phase into the package table;
  - the top registers its output together with the negation.

## Test plan
- Reset, then load 0x8000_0001 (`SAMPLES_PER_BIT`=8) → required response:
  - cycles 1-8: `input_bit`=1, `array_ref_wire` = 0, 46341, 65536, 46341, 0, -46341, -65536, -46341;
  - `array_ref_m_wire` = 0, 0xFFFF4AFB, 0xFFFF0000, …;
  - bits 1-30: `input_bit`=0;
  - bit 31: `input_bit`=1;
  - `frame_done` at cycle 256 only.
- Back-to-back words 0xFFFF_FFFF then 0x0000_0000 → required response:
  - with the macro: 512 contiguous `seg_valid` cycles;
  - without the macro: exactly one `seg_valid`=0 gap cycle between the words.
- `SAMPLES_PER_BIT`=4, word 0xA5A5_A5A5 → carrier sequence 0, 65536, 0, -65536 per bit; `seg_idx` steps every 4 cycles; 128 valid cycles.
- Reset asserted at `seg_idx`=10 → on the next cycle: all outputs 0, `seg_valid`=0; after release, `in_ready`=1 and a new word starts at `seg_idx` 0.
- `in_valid` held high during RUN without the macro → `in_ready`=0 and no word is taken until after `frame_done`.
- With the macro, two extra words offered during RUN → the first is taken, the second is stalled by `in_ready`=0 until the holding register is consumed.
